// File: rtl/ov7670_frame_writer_pkg.sv
// ov7670_frame_writer_pkg: shared frame geometry, writer FSM encoding and RGB565->RGB444 pack.
package ov7670_frame_writer_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_ADDR_W   = 19;
    localparam int FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;

    typedef enum logic [1:0] {SYNC, BLANK, ACTIVE} fw_state_e;

    // hi = R4..R0 G5..G3, lo = G2..G0 B4..B0; keep the top 4 bits of each channel
    function automatic logic [11:0] rgb565_to_rgb444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction
endpackage

// File: rtl/ov7670_frame_writer_packer.sv
// ov7670_byte_packer: pairs camera bytes into one RGB444 pixel; clear_i drops any half pixel.
module ov7670_byte_packer
    import ov7670_frame_writer_pkg::*;
(
    input  logic        CLK25,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  din_i,
    output logic        pixel_valid_o,
    output logic [11:0] pixel_o
);
    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    always_comb begin
        phase_d = clear_i ? 1'b0 : (accept_i ? ~phase_q : phase_q);
        hi_d    = (accept_i && !clear_i && !phase_q) ? din_i : hi_q;
    end

    always_ff @(posedge CLK25) begin
        if (reset) begin
            phase_q <= 1'b0;
            hi_q    <= 8'd0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    assign pixel_valid_o = accept_i & phase_q & ~clear_i;
    assign pixel_o       = rgb565_to_rgb444(hi_q, din_i);
endmodule

// File: rtl/ov7670_frame_writer.sv
// ov7670_frame_writer: frame-sync FSM, line/column addressing and the frame-buffer write port.
module ov7670_frame_writer
    import ov7670_frame_writer_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              CLK25,
    input  logic              reset,
    input  logic              capture_en_i,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        din_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [11:0]       wr_data_o,
    output logic              frame_done_o,
    output logic [9:0]        line_count_o,
    output logic              err_short_line_o
);
    localparam int COL_W = $clog2(H_ACTIVE + 1);

    fw_state_e         state_q, state_d;
    logic              vsync_q, href_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [9:0]        lc_q, lc_d;
    logic              over_q, over_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              fs, fe, ls, le, active, accept, pix_valid, line_ok;
    logic [11:0]       pixel;

    assign fs     = vsync_q & ~vsync_i;
    assign fe     = ~vsync_q & vsync_i;
    assign ls     = ~href_q & href_i;
    assign le     = href_q & ~href_i;
    assign active = (state_q == ACTIVE);
    assign accept = active & ~fe & href_i & byte_valid_i;
    // over_q marks lines past V_ACTIVE, which the saturated line count cannot distinguish
    assign line_ok = (lc_q != 10'd0) & ~over_q;

    ov7670_byte_packer u_packer (
        .CLK25         (CLK25),
        .reset         (reset),
        .clear_i       (~active | fe | ~href_i),
        .accept_i      (accept),
        .din_i         (din_i),
        .pixel_valid_o (pix_valid),
        .pixel_o       (pixel)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        base_d    = base_q;
        lc_d      = lc_q;
        over_d    = over_q;
        err_d     = err_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            SYNC:  state_d = vsync_i ? BLANK : SYNC;
            BLANK: begin
                if (fs && capture_en_i) begin
                    state_d = ACTIVE;
                    col_d   = '0;
                    base_d  = '0;
                    lc_d    = '0;
                    over_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (fe) begin
                    done_d  = 1'b1;
                    state_d = BLANK;
                end else begin
                    if (ls) begin
                        over_d = over_q | (lc_q == 10'(V_ACTIVE));
                        lc_d   = (lc_q == 10'(V_ACTIVE)) ? lc_q : lc_q + 10'd1;
                    end
                    if (pix_valid) begin
                        if (line_ok && col_q < COL_W'(H_ACTIVE)) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = base_q + ADDR_W'(col_q);
                            wr_data_d = pixel;
                        end
                        col_d = (col_q < COL_W'(H_ACTIVE)) ? col_q + COL_W'(1) : col_q;
                    end
                    if (le) begin
                        if (line_ok) begin
                            err_d  = err_q | (col_q < COL_W'(H_ACTIVE));
                            base_d = (lc_q < 10'(V_ACTIVE)) ? base_q + ADDR_W'(H_ACTIVE) : base_q;
                        end
                        col_d = '0;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge CLK25) begin
        if (reset) begin
            state_q   <= SYNC;
            vsync_q   <= 1'b1;
            href_q    <= 1'b0;
            col_q     <= '0;
            base_q    <= '0;
            lc_q      <= '0;
            over_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            vsync_q   <= vsync_i;
            href_q    <= href_i;
            col_q     <= col_d;
            base_q    <= base_d;
            lc_q      <= lc_d;
            over_q    <= over_d;
            err_q     <= err_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en_o          = wr_en_q;
    assign wr_addr_o        = wr_addr_q;
    assign wr_data_o        = wr_data_q;
    assign frame_done_o     = done_q;
    assign line_count_o     = lc_q;
    assign err_short_line_o = err_q;
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// tb_ov7670_frame_writer: directed frames against a write scoreboard of expected {addr,data}.
module tb_ov7670_frame_writer;
    logic        CLK25 = 1'b0;
    logic        reset = 1'b1;
    logic        capture_en_i = 1'b0, vsync_i = 1'b1, href_i = 1'b0, byte_valid_i = 1'b0;
    logic [7:0]  din_i = 8'd0;
    logic        wr_en_o, frame_done_o, err_short_line_o;
    logic [18:0] wr_addr_o;
    logic [11:0] wr_data_o;
    logic [9:0]  line_count_o;

    int total = 0, bad = 0;
    int line_no = 0, col = 0;
    bit cap = 0;
    logic [30:0] q[$];

    ov7670_frame_writer dut (
        .CLK25(CLK25), .reset(reset), .capture_en_i(capture_en_i), .vsync_i(vsync_i),
        .href_i(href_i), .byte_valid_i(byte_valid_i), .din_i(din_i), .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .frame_done_o(frame_done_o),
        .line_count_o(line_count_o), .err_short_line_o(err_short_line_o)
    );

    always #20 CLK25 = ~CLK25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo);
        logic [5:0] g6;
        logic [4:0] r5, b5;
        r5 = hi[7:3];
        g6 = {hi[2:0], lo[7:5]};
        b5 = lo[4:0];
        return {r5[4:1], g6[5:2], b5[4:1]};
    endfunction

    always @(negedge CLK25) begin
        if (wr_en_o === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_wr observed addr=%0d data=%0h expected no write", wr_addr_o, wr_data_o);
            end else
                chk("wr_addr_data", {1'b0, wr_addr_o, wr_data_o}, {1'b0, q.pop_front()});
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK25);
            #1;
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        byte_valid_i = 1'b1;
        din_i = b;
        cyc();
        byte_valid_i = 1'b0;
    endtask

    task automatic expect_pixel(input logic [7:0] hi, input logic [7:0] lo);
        if (cap && line_no >= 1 && line_no <= 480 && col < 640)
            q.push_back({19'((line_no - 1) * 640 + col), exp_pix(hi, lo)});
        if (col < 640) col++;
    endtask

    task automatic put_pixel(input logic [7:0] hi, input logic [7:0] lo);
        put_byte(hi);
        expect_pixel(hi, lo);
        put_byte(lo);
    endtask

    // checks that the write appears exactly one cycle after the second byte
    task automatic pixel_timed(input logic [7:0] hi, input logic [7:0] lo, input logic [11:0] want);
        put_byte(hi);
        expect_pixel(hi, lo);
        byte_valid_i = 1'b1;
        din_i = lo;
        @(negedge CLK25);
        chk("wr_en_before", {31'd0, wr_en_o}, 32'd0);
        cyc();
        byte_valid_i = 1'b0;
        @(negedge CLK25);
        chk("wr_en_after", {31'd0, wr_en_o}, 32'd1);
        chk("wr_data_lit", {20'd0, wr_data_o}, {20'd0, want});
        cyc();
        @(negedge CLK25);
        chk("wr_en_pulse", {31'd0, wr_en_o}, 32'd0);
        cyc();
    endtask

    task automatic send_line(input int npix, input bit odd);
        href_i = 1'b1;
        line_no++;
        col = 0;
        cyc();
        for (int p = 0; p < npix; p++)
            put_pixel(8'($urandom), 8'($urandom));
        if (odd) put_byte(8'hA5);
        href_i = 1'b0;
        cyc(2);
    endtask

    task automatic frame_start(input bit en);
        vsync_i = 1'b1;
        capture_en_i = en;
        cyc(3);
        vsync_i = 1'b0;
        cap = en;
        line_no = 0;
        cyc(2);
    endtask

    task automatic frame_end(input bit exp_done, input string tag);
        vsync_i = 1'b1;
        cyc();
        @(negedge CLK25);
        chk({tag, "_frame_done"}, {31'd0, frame_done_o}, {31'd0, exp_done});
        cyc();
        @(negedge CLK25);
        chk({tag, "_done_pulse"}, {31'd0, frame_done_o}, 32'd0);
        chk({tag, "_q_empty"}, q.size(), 32'd0);
        cap = 0;
    endtask

    initial begin
        cyc(2);
        @(negedge CLK25);
        chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("rst_wr_addr", {13'd0, wr_addr_o}, 32'd0);
        chk("rst_wr_data", {20'd0, wr_data_o}, 32'd0);
        chk("rst_done", {31'd0, frame_done_o}, 32'd0);
        chk("rst_lc", {22'd0, line_count_o}, 32'd0);
        chk("rst_err", {31'd0, err_short_line_o}, 32'd0);
        reset = 1'b0;
        cyc();

        frame_start(1);
        for (int l = 0; l < 3; l++) send_line(640, 0);
        chk("t1_lc", {22'd0, line_count_o}, 32'd3);
        chk("t1_err", {31'd0, err_short_line_o}, 32'd0);
        frame_end(1, "t1");

        frame_start(1);
        href_i = 1'b1;
        line_no++;
        col = 0;
        cyc();
        pixel_timed(8'hF8, 8'h1F, 12'hF0F);
        pixel_timed(8'h07, 8'hE0, 12'h0F0);
        href_i = 1'b0;
        cyc(2);
        frame_end(1, "t2");

        frame_start(1);
        chk("t3_err_clr", {31'd0, err_short_line_o}, 32'd0);
        send_line(600, 0);
        send_line(700, 0);
        chk("t3_err", {31'd0, err_short_line_o}, 32'd1);
        frame_end(1, "t3");

        frame_start(1);
        send_line(5, 1);
        send_line(5, 0);
        frame_end(1, "t4");

        frame_start(1);
        for (int l = 0; l < 100; l++) send_line(2, 0);
        chk("t5_lc", {22'd0, line_count_o}, 32'd100);
        href_i = 1'b1;
        cyc();
        reset = 1'b1;
        cap = 0;
        cyc();
        @(negedge CLK25);
        chk("t5_rst_lc", {22'd0, line_count_o}, 32'd0);
        chk("t5_rst_wr", {31'd0, wr_en_o}, 32'd0);
        reset = 1'b0;
        href_i = 1'b0;
        cyc(2);
        for (int l = 0; l < 3; l++) send_line(4, 0);
        frame_end(0, "t5a");
        frame_start(1);
        send_line(4, 0);
        frame_end(1, "t5b");

        frame_start(0);
        capture_en_i = 1'b1;
        for (int l = 0; l < 3; l++) send_line(4, 0);
        frame_end(0, "t6a");
        frame_start(1);
        send_line(8, 0);
        send_line(3, 0);
        chk("t6_lc", {22'd0, line_count_o}, 32'd2);
        frame_end(1, "t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
